rr_timeout_arbiter: RTL and testbench

//   N-port round-robin output-port arbiter for the NoC router switch allocator.

---
 rtl/rr_timeout_arbiter.sv | 139 +++++++++++++
 tb/tb_rr_timeout_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter for the NoC switch allocator.
// A grant is held until the request drops or the port's header-latched timeout expires.
module rr_timeout_arbiter #(
  parameter  int NPORTS    = 5,
  parameter  int LEN_W     = 12,
  parameter  int FID_W     = 3,
  parameter  int HEADER_ID = 1,
  localparam int ID_W      = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req_i,
  input  logic [NPORTS*FID_W-1:0]   flit_id_i,
  input  logic [NPORTS*LEN_W-1:0]   length_i,
  output logic [NPORTS-1:0]         grant_o,
  output logic                      grant_valid_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic [NPORTS-1:0]         timeout_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NPORTS-1:0]   grant_q, grant_d;
  logic [NPORTS-1:0]   timeout_q, timeout_d;
  logic [LEN_W-1:0]    count_q [NPORTS];
  logic [LEN_W-1:0]    count_d [NPORTS];
  logic [LEN_W-1:0]    limit_q [NPORTS];
  logic [LEN_W-1:0]    limit_d [NPORTS];

  logic [NPORTS-1:0]   timesUp;
  logic                keep;
  logic                found;
  logic [ID_W-1:0]     pick;
  int                  afterOwner;
  int                  searchBase;
  int                  searchSpan;
  int                  idx;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      timesUp[p] = (count_q[p] >= limit_q[p]);
      limit_d[p] = (flit_id_i[p*FID_W +: FID_W] == FID_W'(HEADER_ID))
                   ? length_i[p*LEN_W +: LEN_W] : limit_q[p];
    end
  end

  // The holder is skipped when it releases, so the search covers only the other ports.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    timeout_d  = '0;
    found      = 1'b0;
    pick       = '0;
    idx        = 0;
    keep       = (state_q == HOLD) && req_i[owner_q] && !timesUp[owner_q];
    afterOwner = int'(owner_q) + 1;
    if (afterOwner >= NPORTS) afterOwner = 0;
    searchBase = (state_q == IDLE) ? int'(ptr_q) : afterOwner;
    searchSpan = (state_q == IDLE) ? NPORTS : NPORTS - 1;

    for (int i = 0; i < NPORTS; i++) begin
      idx = searchBase + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && (i < searchSpan) && req_i[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          owner_d = pick;
        end
      end
      HOLD: begin
        if (!keep) begin
          ptr_d = ID_W'(afterOwner);
          if (req_i[owner_q] && timesUp[owner_q]) timeout_d[owner_q] = 1'b1;
          if (found) begin
            state_d = HOLD;
            owner_d = pick;
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase

    grant_d = (state_d == HOLD) ? (NPORTS'(1) << owner_d) : '0;

    for (int p = 0; p < NPORTS; p++) begin
      if (keep && (int'(owner_q) == p))
        count_d[p] = (count_q[p] == '1) ? count_q[p] : count_q[p] + LEN_W'(1);
      else
        count_d[p] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      timeout_q <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        count_q[p] <= '0;
        limit_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      for (int p = 0; p < NPORTS; p++) begin
        count_q[p] <= count_d[p];
        limit_q[p] <= limit_d[p];
      end
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign grant_id_o    = owner_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed self-checking bench for rr_timeout_arbiter: reset, hold/timeout,
// rotation, request drop, header re-latch and reset mid-grant.
module tb_rr_timeout_arbiter;

  localparam int NPORTS    = 5;
  localparam int LEN_W     = 12;
  localparam int FID_W     = 3;
  localparam int HEADER_ID = 1;
  localparam int ID_W      = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NPORTS-1:0]       req;
  logic [NPORTS*FID_W-1:0] flitId;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0]       grant;
  logic                    grantValid;
  logic [ID_W-1:0]         grantId;
  logic [NPORTS-1:0]       timeout;

  int assertCount = 0;
  int failCount   = 0;
  bit monitorOn   = 1'b0;

  rr_timeout_arbiter #(
    .NPORTS(NPORTS), .LEN_W(LEN_W), .FID_W(FID_W), .HEADER_ID(HEADER_ID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .flit_id_i(flitId),
    .length_i(length),
    .grant_o(grant),
    .grant_valid_o(grantValid),
    .grant_id_o(grantId),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // hdrPort = NPORTS marks a header on every port; -1 means no header.
  task automatic applyStimulus(input logic [NPORTS-1:0] r, input int hdrPort, input int hdrLen);
    req    = r;
    flitId = '0;
    length = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (hdrPort == p || hdrPort == NPORTS) begin
        flitId[p*FID_W +: FID_W] = FID_W'(HEADER_ID);
        length[p*LEN_W +: LEN_W] = LEN_W'(hdrLen);
      end
    end
  endtask

  task automatic applyReset;
    applyStimulus('0, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic checkGrant(input string tag, input logic [NPORTS-1:0] expGrant,
                            input logic [NPORTS-1:0] expTimeout);
    logic [ID_W-1:0] expId;
    expId = '0;
    for (int i = 0; i < NPORTS; i++)
      if (expGrant[i]) expId = ID_W'(i);
    checkOutput({tag, ".grant"},   32'(grant),      32'(expGrant));
    checkOutput({tag, ".id"},      32'(grantId),    32'(expId));
    checkOutput({tag, ".valid"},   32'(grantValid), 32'(|expGrant));
    checkOutput({tag, ".timeout"}, 32'(timeout),    32'(expTimeout));
  endtask

  // Grant must be one-hot or zero and agree with grant_id/grant_valid on every cycle.
  always @(negedge clk) begin
    if (monitorOn) begin
      logic [ID_W-1:0] idFromGrant;
      idFromGrant = '0;
      for (int i = 0; i < NPORTS; i++)
        if (grant[i]) idFromGrant = ID_W'(i);
      checkOutput("onehot",    32'($onehot0(grant)), 32'(1));
      checkOutput("idMatch",   32'(grantId),         32'(idFromGrant));
      checkOutput("validMatch", 32'(grantValid),     32'(|grant));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NPORTS-1:0] seq [6];
    logic [NPORTS-1:0] prev;

    // Reset held two cycles with every port requesting.
    rst = 1'b1;
    applyStimulus('1, -1, 0);
    tick();
    tick();
    monitorOn = 1'b1;
    checkGrant("reset", 5'b00000, 5'b00000);
    rst = 1'b0;
    tick();
    checkGrant("resetRelease", 5'b00001, 5'b00000);

    // Port 2, length 3: four grant cycles, a one-cycle gap with timeout, then regrant.
    applyReset();
    applyStimulus(5'b00000, 2, 3);
    tick();
    applyStimulus(5'b00100, -1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkGrant("hold", 5'b00100, 5'b00000);
    end
    tick();
    checkGrant("holdExpire", 5'b00000, 5'b00100);
    tick();
    checkGrant("regrant", 5'b00100, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkGrant("regrantHold", 5'b00100, 5'b00000);
    end
    tick();
    checkGrant("regrantExpire", 5'b00000, 5'b00100);

    // All limits zero, everyone requesting: one grant per cycle in rotation.
    applyReset();
    applyStimulus(5'b00000, NPORTS, 0);
    tick();
    applyStimulus(5'b11111, -1, 0);
    seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00100;
    seq[3] = 5'b01000; seq[4] = 5'b10000; seq[5] = 5'b00001;
    prev = 5'b00000;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkGrant("rotate", seq[k], prev);
      prev = seq[k];
    end

    // Port 1 drops its request mid-packet: hand-off to port 4 without timeout.
    applyReset();
    applyStimulus(5'b00000, 1, 100);
    tick();
    applyStimulus(5'b10010, -1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkGrant("dropHold", 5'b00010, 5'b00000);
    end
    applyStimulus(5'b10000, -1, 0);
    tick();
    checkGrant("dropHandoff", 5'b10000, 5'b00000);

    // Port 0 at count 10 of 50 gets a new header with length 4.
    applyReset();
    applyStimulus(5'b00000, 0, 50);
    tick();
    applyStimulus(5'b00001, -1, 0);
    tick();
    checkGrant("relatchGrant", 5'b00001, 5'b00000);
    for (int i = 0; i < 10; i++) tick();
    checkGrant("relatchCount10", 5'b00001, 5'b00000);
    applyStimulus(5'b00001, 0, 4);
    tick();
    checkGrant("relatchEdge", 5'b00001, 5'b00000);
    applyStimulus(5'b00001, -1, 0);
    tick();
    checkGrant("relatchRevoke", 5'b00000, 5'b00001);
    tick();
    checkGrant("relatchRegrant", 5'b00001, 5'b00000);

    // Reset while port 3 holds at count 7; search restarts from port 0.
    applyReset();
    applyStimulus(5'b00000, 3, 100);
    tick();
    applyStimulus(5'b01000, -1, 0);
    tick();
    checkGrant("midResetGrant", 5'b01000, 5'b00000);
    for (int i = 0; i < 7; i++) tick();
    checkGrant("midResetHold", 5'b01000, 5'b00000);
    rst = 1'b1;
    tick();
    checkGrant("midReset", 5'b00000, 5'b00000);
    rst = 1'b0;
    applyStimulus(5'b11111, -1, 0);
    tick();
    checkGrant("midResetRestart", 5'b00001, 5'b00000);

    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
